regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the ALU writeback path and the load

---
 rtl/regfile_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Shares the register-file write port between ALU and load writeback;
//            partial loads merge via read-modify-write. Option: WB_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int LOAD_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_reg,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic [DATA_W/8-1:0] ld_byte_en,
    output logic [ADDR_W-1:0]   rf_read_reg,
    input  logic [DATA_W-1:0]   rf_read_data,
    output logic [1:0]          rf_write_en,
    output logic [ADDR_W-1:0]   rf_write_reg,
    output logic [DATA_W-1:0]   rf_write_data
`ifdef WB_FORWARD_EN
    ,
    output logic                fwd_valid,
    output logic [ADDR_W-1:0]   fwd_reg,
    output logic [DATA_W-1:0]   fwd_data
`endif
);

    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MERGE_RD = 2'd1,
        MERGE_WR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              rr_ptr;      // 0 = ALU next, 1 = load next
    logic              idle;
    logic              both_valid;
    logic              ld_wins;
    logic              alu_grant;
    logic              ld_grant;
    logic              ld_full_wr;
    logic              ld_merge;

    logic [ADDR_W-1:0] lat_reg;
    logic [DATA_W-1:0] lat_data;
    logic [LANES-1:0]  lat_mask;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] base_word;
    logic [DATA_W-1:0] merged;

    assign idle       = (state == IDLE);
    assign both_valid = alu_valid & ld_valid;
    assign ld_wins    = ld_valid & (~alu_valid | (LOAD_PRIO != 0) | rr_ptr);
    assign alu_grant  = idle & ~reset & alu_valid & ~ld_wins;
    assign ld_grant   = idle & ~reset & ld_wins;

    assign alu_ready  = alu_grant;
    assign ld_ready   = ld_grant;

    // Register 0 and empty masks are consumed without touching the register file
    assign ld_full_wr = ld_grant & (ld_reg != '0) & (&ld_byte_en);
    assign ld_merge   = ld_grant & (ld_reg != '0) & (|ld_byte_en) & ~(&ld_byte_en);

    // Bypass an in-flight write to the same register during the merge read
    assign base_word  = (wr_en && (wr_reg == lat_reg)) ? wr_data : rf_read_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged[8*i +: 8] = lat_mask[i] ? lat_data[8*i +: 8] : base_word[8*i +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rf_read_reg = '0;
        case (state)
            IDLE: begin
                if (ld_merge) begin
                    state_nxt = MERGE_RD;
                end
            end
            MERGE_RD: begin
                rf_read_reg = lat_reg;
                state_nxt   = MERGE_WR;
            end
            MERGE_WR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= 1'b0;
            wr_en    <= 1'b0;
            wr_reg   <= '0;
            wr_data  <= '0;
            lat_reg  <= '0;
            lat_data <= '0;
            lat_mask <= '0;
        end else begin
            wr_en <= 1'b0;
            if (idle && both_valid) begin
                rr_ptr <= ~rr_ptr;
            end
            if (alu_grant && (alu_reg != '0)) begin
                wr_en   <= 1'b1;
                wr_reg  <= alu_reg;
                wr_data <= alu_data;
            end
            if (ld_full_wr) begin
                wr_en   <= 1'b1;
                wr_reg  <= ld_reg;
                wr_data <= ld_data;
            end
            if (ld_merge) begin
                lat_reg  <= ld_reg;
                lat_data <= ld_data;
                lat_mask <= ld_byte_en;
            end
            if (state == MERGE_RD) begin
                wr_en   <= 1'b1;
                wr_reg  <= lat_reg;
                wr_data <= merged;
            end
        end
    end

    assign rf_write_en   = {2{wr_en}};
    assign rf_write_reg  = wr_reg;
    assign rf_write_data = wr_data;

`ifdef WB_FORWARD_EN
    assign fwd_valid = wr_en;
    assign fwd_reg   = wr_reg;
    assign fwd_data  = wr_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed self-checking bench for regfile_wb_arbiter (round-robin and
//            load-priority instances sharing one stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_reg, ld_reg;
    logic [31:0] alu_data, ld_data;
    logic [3:0]  ld_byte_en;

    logic        alu_ready, ld_ready, p_alu_ready, p_ld_ready;
    logic [4:0]  rf_read_reg, rf_write_reg, p_rf_read_reg, p_rf_write_reg;
    logic [31:0] rf_write_data, p_rf_write_data;
    logic [1:0]  rf_write_en, p_rf_write_en;
    logic [31:0] regs [32];
    logic [31:0] rf_read_data, p_rf_read_data;
`ifdef WB_FORWARD_EN
    logic        fwd_valid, p_fwd_valid;
    logic [4:0]  fwd_reg, p_fwd_reg;
    logic [31:0] fwd_data, p_fwd_data;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rf_read_data   = regs[rf_read_reg];
    assign p_rf_read_data = regs[p_rf_read_reg];

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .LOAD_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
        .ld_byte_en(ld_byte_en), .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data)
`ifdef WB_FORWARD_EN
        , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .LOAD_PRIO(1)) dut_p (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(p_alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(p_ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
        .ld_byte_en(ld_byte_en), .rf_read_reg(p_rf_read_reg), .rf_read_data(p_rf_read_data),
        .rf_write_en(p_rf_write_en), .rf_write_reg(p_rf_write_reg), .rf_write_data(p_rf_write_data)
`ifdef WB_FORWARD_EN
        , .fwd_valid(p_fwd_valid), .fwd_reg(p_fwd_reg), .fwd_data(p_fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid  = 1'b0;
        ld_valid   = 1'b0;
        alu_reg    = '0;
        alu_data   = '0;
        ld_reg     = '0;
        ld_data    = '0;
        ld_byte_en = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[8] = 32'h12345678;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_en", 64'(rf_write_en), 64'd0);
        check("rst_data", 64'(rf_write_data), 64'd0);
        check("rst_rdreg", 64'(rf_read_reg), 64'd0);
        reset = 1'b0;

        // ALU write to reg 5
        next_cycle();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_alu_ready", 64'(alu_ready), 64'd1);
        check("t1_en_N", 64'(rf_write_en), 64'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t1_en_N1", 64'(rf_write_en), 64'd3);
        check("t1_reg", 64'(rf_write_reg), 64'd5);
        check("t1_data", 64'(rf_write_data), 64'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("t1_en_N2", 64'(rf_write_en), 64'd0);

        // Round-robin: ALU, LD, ALU, LD
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (k < 4) begin
                alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'hA0 + k;
                ld_valid = 1'b1; ld_reg = 5'd2; ld_data = 32'hB0 + k; ld_byte_en = 4'hF;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (k < 4) begin
                check($sformatf("t2_alu_ready%0d", k), 64'(alu_ready), 64'((k % 2) == 0));
                check($sformatf("t2_ld_ready%0d", k), 64'(ld_ready), 64'((k % 2) == 1));
            end
            if (k > 0) begin
                check($sformatf("t2_en%0d", k), 64'(rf_write_en), 64'd3);
                check($sformatf("t2_reg%0d", k), 64'(rf_write_reg), ((k - 1) % 2 == 0) ? 64'd1 : 64'd2);
                check($sformatf("t2_data%0d", k), 64'(rf_write_data),
                      ((k - 1) % 2 == 0) ? 64'(32'hA0 + k - 1) : 64'(32'hB0 + k - 1));
            end
        end

        // Partial load merge into reg 8; ALU request held off during the merge
        next_cycle();
        ld_valid = 1'b1; ld_reg = 5'd8; ld_data = 32'h0000ABCD; ld_byte_en = 4'b0011;
        @(negedge clk);
        check("t3_ld_ready", 64'(ld_ready), 64'd1);
        next_cycle();
        idle_inputs();
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
        @(negedge clk);
        check("t3_rdreg", 64'(rf_read_reg), 64'd8);
        check("t3_rdy_N1", 64'({alu_ready, ld_ready}), 64'd0);
        check("t3_en_N1", 64'(rf_write_en), 64'd0);
        next_cycle();
        @(negedge clk);
        check("t3_rdy_N2", 64'({alu_ready, ld_ready}), 64'd0);
        check("t3_en_N2", 64'(rf_write_en), 64'd3);
        check("t3_reg", 64'(rf_write_reg), 64'd8);
        check("t3_data", 64'(rf_write_data), 64'h1234ABCD);
        next_cycle();
        @(negedge clk);
        check("t3_alu_after", 64'(alu_ready), 64'd1);
        check("t3_en_N3", 64'(rf_write_en), 64'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t3_alu_wr", 64'({rf_write_en, rf_write_reg}), 64'({2'd3, 5'd3}));

        // Register 0 and empty-mask requests: accepted, no write, no merge
        next_cycle();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
        @(negedge clk);
        check("t4_alu0_ready", 64'(alu_ready), 64'd1);
        next_cycle();
        idle_inputs();
        ld_valid = 1'b1; ld_reg = 5'd9; ld_data = 32'h99; ld_byte_en = 4'b0000;
        @(negedge clk);
        check("t4_be0_ready", 64'(ld_ready), 64'd1);
        check("t4_en_a", 64'(rf_write_en), 64'd0);
        next_cycle();
        ld_reg = 5'd0; ld_byte_en = 4'b0011;
        @(negedge clk);
        check("t4_r0_ready", 64'(ld_ready), 64'd1);
        check("t4_en_b", 64'(rf_write_en), 64'd0);
        next_cycle();
        ld_reg = 5'd10; ld_data = 32'h77; ld_byte_en = 4'hF;
        @(negedge clk);
        check("t4_nomerge_ready", 64'(ld_ready), 64'd1);
        check("t4_en_c", 64'(rf_write_en), 64'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t4_full_wr", 64'({rf_write_en, rf_write_reg}), 64'({2'd3, 5'd10}));
        check("t4_full_data", 64'(rf_write_data), 64'h77);

        // Reset during MERGE_RD aborts the merge
        next_cycle();
        ld_valid = 1'b1; ld_reg = 5'd8; ld_data = 32'hAABB0000; ld_byte_en = 4'b1100;
        @(negedge clk);
        check("t5_ld_ready", 64'(ld_ready), 64'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t5_rdreg", 64'(rf_read_reg), 64'd8);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_rdreg", 64'(rf_read_reg), 64'd0);
        check("t5_rst_en", 64'(rf_write_en), 64'd0);
        check("t5_rst_rdy", 64'({alu_ready, ld_ready}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_wr", 64'(rf_write_en), 64'd0);
        next_cycle();
        alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h44;
        @(negedge clk);
        check("t5_alu_ready", 64'(alu_ready), 64'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t5_alu_wr", 64'({rf_write_en, rf_write_reg}), 64'({2'd3, 5'd4}));
        check("t5_alu_data", 64'(rf_write_data), 64'h44);

        // Load priority: load wins every cycle
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k < 3) begin
                alu_valid = 1'b1; alu_reg = 5'd6; alu_data = 32'h66;
                ld_valid = 1'b1; ld_reg = 5'd7; ld_data = 32'hC0 + k; ld_byte_en = 4'hF;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (k < 3) begin
                check($sformatf("t6_rdy%0d", k), 64'({p_ld_ready, p_alu_ready}), 64'd2);
            end
            if (k > 0) begin
                check($sformatf("t6_wr%0d", k), 64'({p_rf_write_en, p_rf_write_reg}), 64'({2'd3, 5'd7}));
                check($sformatf("t6_data%0d", k), 64'(p_rf_write_data), 64'(32'hC0 + k - 1));
`ifdef WB_FORWARD_EN
                check($sformatf("t6_fwd%0d", k), 64'({p_fwd_valid, p_fwd_reg}), 64'({1'b1, 5'd7}));
                check($sformatf("t6_fwd_data%0d", k), 64'(p_fwd_data), 64'(32'hC0 + k - 1));
`endif
            end
        end
        next_cycle();
        @(negedge clk);
        check("t6_idle_en", 64'(p_rf_write_en), 64'd0);
`ifdef WB_FORWARD_EN
        check("t6_fwd_idle", 64'(p_fwd_valid), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
